stream_sign_flip_run_ctrl: RTL and testbench
============================================

Name: stream_sign_flip_run_ctrl

Overview:
- Run sequencer for the stream_sign_flip kernel over its ap_ctrl_hs handshake. Supports single-shot and continuous restart.
- Consumes the kernel's deadlock-monitor `block` indication and acts as a stall watchdog. On a sustained AXIS block it aborts the kernel with a soft-reset pulse and latches a fault for host firmware.
- Sits between the host control register bank and the kernel instance.

Parameters:
- CNT_W, 16, width of timeout register and stall counter.
- RST_CYCLES, 8, length of the kernel_rst pulse during flush (>=1).
- RUN_CNT_W, 32, width of the completed-run counter.

Ports:
- clock  in  1  single design clock.
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately.
- enable  in  1  host run enable (level).
- continuous  in  1  1 = restart automatically after each ap_done while enable=1.
- timeout  in  CNT_W  consecutive blocked cycles that trigger an abort; 0 disables the watchdog.
- block_in  in  1  deadlock-monitor block flag from the kernel.
- ap_idle  in  1  kernel idle.
- ap_ready  in  1  kernel accepted start.
- ap_done  in  1  kernel run complete (1-cycle pulse).
- deadlock_clr  in  1  host acknowledge of a fault (pulse).
- ap_start  out  1  kernel start request.
- kernel_rst  out  1  active-high soft reset to the kernel.
- busy  out  1  1 in any state except IDLE.
- deadlock  out  1  sticky fault flag.
- run_count  out  RUN_CNT_W  completed runs; wraps modulo 2^RUN_CNT_W.
- abort_count  out  8  watchdog aborts; saturates at 255.

Behaviour:
- Reset: state=IDLE. All outputs and counters = 0.
- States: IDLE, START, RUN, FLUSH, FAULT. All outputs are registered.
- IDLE:
  - ap_start=0.
  - If enable=1 and ap_idle=1, go to START on the next edge.
- START:
  - ap_start=1, held until ap_ready=1 is sampled. Go to RUN on that edge; ap_start=0 from the next cycle.
- RUN:
  - ap_start=0.
  - On ap_done=1: run_count += 1.
  - Then, if continuous=1 and enable=1, go to START; otherwise go to IDLE.
  - enable falling mid-run never aborts. The current run completes, then the block returns to IDLE.
- ap_ready and ap_done in the same START cycle: counts as a completed run; take the RUN exit decision directly.
- Watchdog (START and RUN only):
  - stall_cnt increments while block_in=1 and resets to 0 on any cycle with block_in=0. It saturates at all-ones.
  - stall_cnt is cleared on every state change.
  - Trigger: timeout!=0 and the incremented value equals timeout, i.e. abort after exactly `timeout` consecutive blocked cycles.
  - On trigger: go to FLUSH, set deadlock=1, abort_count += 1 (saturating).
- Priority: ap_done in the same cycle as the watchdog trigger → ap_done wins (normal completion, no abort).
- FLUSH:
  - ap_start=0, kernel_rst=1 for exactly RST_CYCLES cycles (internal counter).
  - Then go to FAULT with kernel_rst=0.
  - ap_done/ap_ready/block_in are ignored.
- FAULT:
  - Wait for deadlock_clr=1, then clear deadlock and go to IDLE. enable is ignored here.
  - deadlock_clr in any other state has no effect.
- timeout changed mid-run takes effect immediately; if it drops below stall_cnt, no trigger fires until block_in deasserts.
- busy=1 in START, RUN, FLUSH and FAULT.
- Asynchronous reset mid-FLUSH: kernel_rst drops at once; deadlock and counters clear.

Test Plan:
- Single run: continuous=0, enable 0→1 with ap_idle=1; ap_ready 2 cycles after ap_start rises; ap_done 10 cycles later → ap_start high 3 cycles, run_count=1, IDLE/busy=0 one cycle after done.
- Continuous: continuous=1, enable=1, 3 done pulses, enable dropped during run 3 → run_count=3, ap_start rises the cycle after done 1 and done 2, no restart after done 3.
- Watchdog: timeout=5, block_in held 1 during RUN → FLUSH entered after 5th blocked cycle, kernel_rst high exactly 8 cycles, deadlock=1, abort_count=1; a 4-cycle block followed by 1 idle cycle → no abort.
- Simultaneous: block count reaches timeout in the same cycle as ap_done → run_count increments, deadlock stays 0.
- Fault clear: in FAULT with enable=1, deadlock_clr pulse → deadlock=0, IDLE, then new START; timeout=0 with block_in stuck 1000 cycles → no abort.
- Async reset asserted mid-FLUSH between edges → kernel_rst, deadlock, busy go 0 without a clock edge.

Source files
------------

// File: rtl/stream_sign_flip_run_ctrl_if.sv
// stream_sign_flip_run_ctrl_if: ap_ctrl_hs handshake, soft reset and block flag between the sequencer and the kernel
interface stream_sign_flip_run_ctrl_if;
    logic ap_start;
    logic kernel_rst;
    logic ap_idle;
    logic ap_ready;
    logic ap_done;
    logic block_in;
    modport master (output ap_start, kernel_rst, input ap_idle, ap_ready, ap_done, block_in);
    modport slave (input ap_start, kernel_rst, output ap_idle, ap_ready, ap_done, block_in);
endinterface

// File: rtl/stream_sign_flip_run_ctrl.sv
// stream_sign_flip_run_ctrl: run sequencer and stall watchdog for the stream_sign_flip kernel
module stream_sign_flip_run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 8,
    parameter int RUN_CNT_W  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 continuous,
    input  logic [CNT_W-1:0]     timeout,
    input  logic                 deadlock_clr,
    stream_sign_flip_run_ctrl_if.master kif,
    output logic                 busy,
    output logic                 deadlock,
    output logic [RUN_CNT_W-1:0] run_count,
    output logic [7:0]           abort_count
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, START, RUN, FLUSH, FAULT} state_t;
    state_t state, state_nxt, done_exit;
    logic [CNT_W-1:0] stall, stall_nxt, stall_inc;
    logic [RC_W-1:0] rc, rc_nxt;
    logic run_inc, abort, clr, trig;
    logic ap_start_q, kernel_rst_q;
    assign kif.ap_start   = ap_start_q;
    assign kif.kernel_rst = kernel_rst_q;
    always_comb begin
        state_nxt = state;
        stall_nxt = '0;
        rc_nxt    = '0;
        run_inc   = 1'b0;
        abort     = 1'b0;
        clr       = 1'b0;
        stall_inc = (&stall) ? stall : stall + 1'b1;
        trig      = kif.block_in && (timeout != '0) &&
                    (({1'b0, stall} + (CNT_W+1)'(1)) == {1'b0, timeout});
        done_exit = (continuous && enable) ? START : IDLE;
        case (state)
            IDLE:  if (enable && kif.ap_idle) state_nxt = START;
            START: begin
                if (kif.ap_ready && kif.ap_done) begin
                    run_inc   = 1'b1;
                    state_nxt = done_exit;
                end else if (trig) begin
                    abort     = 1'b1;
                    state_nxt = FLUSH;
                end else if (kif.ap_ready) state_nxt = RUN;
                else stall_nxt = kif.block_in ? stall_inc : '0;
            end
            RUN: begin
                if (kif.ap_done) begin
                    run_inc   = 1'b1;
                    state_nxt = done_exit;
                end else if (trig) begin
                    abort     = 1'b1;
                    state_nxt = FLUSH;
                end else stall_nxt = kif.block_in ? stall_inc : '0;
            end
            FLUSH: begin
                if (rc == RC_W'(RST_CYCLES - 1)) state_nxt = FAULT;
                else rc_nxt = rc + 1'b1;
            end
            FAULT: begin
                if (deadlock_clr) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            stall        <= '0;
            rc           <= '0;
            ap_start_q   <= 1'b0;
            kernel_rst_q <= 1'b0;
            busy         <= 1'b0;
            deadlock     <= 1'b0;
            run_count    <= '0;
            abort_count  <= '0;
        end else begin
            state        <= state_nxt;
            stall        <= stall_nxt;
            rc           <= rc_nxt;
            ap_start_q   <= state_nxt == START;
            kernel_rst_q <= state_nxt == FLUSH;
            busy         <= state_nxt != IDLE;
            deadlock     <= abort ? 1'b1 : clr ? 1'b0 : deadlock;
            run_count    <= run_count + RUN_CNT_W'(run_inc);
            abort_count  <= (abort && abort_count != 8'hff) ? abort_count + 8'd1 : abort_count;
        end
    end
endmodule

// File: tb/tb_stream_sign_flip_run_ctrl.sv
// tb_stream_sign_flip_run_ctrl: directed vector table plus multi-cycle sequences for the run sequencer
module tb_stream_sign_flip_run_ctrl;
    logic clock = 1'b0;
    logic reset, enable, continuous, deadlock_clr;
    logic [15:0] timeout;
    logic busy, deadlock;
    logic [31:0] run_count;
    logic [7:0] abort_count;
    int checks = 0;
    int errors = 0;
    stream_sign_flip_run_ctrl_if kif ();
    stream_sign_flip_run_ctrl dut (
        .clock(clock), .reset(reset), .enable(enable), .continuous(continuous),
        .timeout(timeout), .deadlock_clr(deadlock_clr), .kif(kif),
        .busy(busy), .deadlock(deadlock), .run_count(run_count), .abort_count(abort_count)
    );
    always #5 clock = ~clock;
    typedef struct {
        logic en, cont, idle, rdy, done, blk;
        logic start, bsy, krst, dl;
        int runs;
    } vec_t;
    vec_t vecs[$];
    task automatic add(input logic en, cont, idle, rdy, done, blk, start, bsy, krst, dl, input int runs);
        vec_t v;
        v.en = en; v.cont = cont; v.idle = idle; v.rdy = rdy; v.done = done; v.blk = blk;
        v.start = start; v.bsy = bsy; v.krst = krst; v.dl = dl; v.runs = runs;
        vecs.push_back(v);
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic zero_in();
        enable = 0; continuous = 0; deadlock_clr = 0; timeout = '0;
        kif.ap_idle = 1; kif.ap_ready = 0; kif.ap_done = 0; kif.block_in = 0;
    endtask
    task automatic rst_dut();
        zero_in();
        reset = 1;
        tick();
        reset = 0;
    endtask
    initial begin
        logic seen;
        zero_in();
        kif.ap_idle = 0;
        reset = 1;
        #2;
        chk("reset_outs", {kif.ap_start, kif.kernel_rst, busy, deadlock}, 4'b0000);
        chk("reset_runs", run_count, 0);
        chk("reset_aborts", abort_count, 0);
        tick();
        reset = 0;
        add(1,0,1,0,0,0, 1,1,0,0, 0);
        add(1,0,0,0,0,1, 1,1,0,0, 0);
        add(1,0,0,0,0,0, 1,1,0,0, 0);
        add(1,0,0,1,0,0, 0,1,0,0, 0);
        for (int i = 0; i < 9; i++) add(1,0,0,0,0,i[0], 0,1,0,0, 0);
        add(0,0,1,0,1,0, 0,0,0,0, 1);
        add(0,0,1,0,0,0, 0,0,0,0, 1);
        foreach (vecs[i]) begin
            enable = vecs[i].en; continuous = vecs[i].cont; kif.ap_idle = vecs[i].idle;
            kif.ap_ready = vecs[i].rdy; kif.ap_done = vecs[i].done; kif.block_in = vecs[i].blk;
            tick();
            chk($sformatf("vec%0d_start_busy_krst_dl", i), {kif.ap_start, busy, kif.kernel_rst, deadlock},
                {vecs[i].start, vecs[i].bsy, vecs[i].krst, vecs[i].dl});
            chk($sformatf("vec%0d_runs", i), run_count, 64'(vecs[i].runs));
        end
        rst_dut();
        continuous = 1; enable = 1;
        tick(); chk("cont_start1", kif.ap_start, 1);
        kif.ap_ready = 1; tick(); kif.ap_ready = 0; chk("cont_run1", {kif.ap_start, busy}, 2'b01);
        repeat (3) tick();
        kif.ap_done = 1; tick(); kif.ap_done = 0;
        chk("cont_restart1", kif.ap_start, 1); chk("cont_runs1", run_count, 1);
        kif.ap_ready = 1; tick(); kif.ap_ready = 0; chk("cont_run2", kif.ap_start, 0);
        repeat (2) tick();
        kif.ap_done = 1; tick(); kif.ap_done = 0;
        chk("cont_restart2", kif.ap_start, 1); chk("cont_runs2", run_count, 2);
        kif.ap_ready = 1; tick(); kif.ap_ready = 0;
        enable = 0;
        repeat (3) tick();
        chk("cont_run3_busy", busy, 1);
        kif.ap_done = 1; tick(); kif.ap_done = 0;
        chk("cont_end", {kif.ap_start, busy}, 2'b00); chk("cont_runs3", run_count, 3);
        tick(); chk("cont_no_restart", kif.ap_start, 0);
        rst_dut();
        timeout = 5; enable = 1;
        tick(); kif.ap_ready = 1; tick(); kif.ap_ready = 0; enable = 0;
        kif.block_in = 1; repeat (4) tick(); kif.block_in = 0; tick();
        chk("wd_short_block", {kif.kernel_rst, deadlock, busy}, 3'b001);
        kif.block_in = 1; repeat (4) tick();
        chk("wd_4th_block", kif.kernel_rst, 0);
        tick();
        chk("wd_trigger", {kif.kernel_rst, deadlock, kif.ap_start}, 3'b110);
        chk("wd_aborts", abort_count, 1);
        for (int i = 1; i < 8; i++) begin
            kif.ap_done = (i == 3);
            tick();
            chk($sformatf("wd_flush%0d", i), kif.kernel_rst, 1);
        end
        kif.ap_done = 0; kif.block_in = 0;
        tick();
        chk("wd_fault", {kif.kernel_rst, busy, deadlock}, 3'b011);
        chk("wd_done_ignored", run_count, 0);
        enable = 1;
        repeat (2) tick();
        chk("fault_hold", {busy, deadlock, kif.ap_start}, 3'b110);
        deadlock_clr = 1; tick(); deadlock_clr = 0;
        chk("fault_clear", {busy, deadlock}, 2'b00);
        tick(); chk("fault_restart", kif.ap_start, 1);
        rst_dut();
        timeout = 3; enable = 1;
        tick(); kif.ap_ready = 1; tick(); kif.ap_ready = 0; enable = 0;
        kif.block_in = 1; repeat (2) tick();
        kif.ap_done = 1; tick(); kif.ap_done = 0; kif.block_in = 0;
        chk("simul_runs", run_count, 1);
        chk("simul_state", {deadlock, kif.kernel_rst, busy}, 3'b000);
        chk("simul_aborts", abort_count, 0);
        rst_dut();
        enable = 1;
        tick(); kif.ap_ready = 1; tick(); kif.ap_ready = 0; enable = 0;
        kif.block_in = 1; seen = 0;
        repeat (1000) begin
            tick();
            if (kif.kernel_rst || deadlock) seen = 1;
        end
        chk("tmo0_no_abort", seen, 0);
        kif.ap_done = 1; tick(); kif.ap_done = 0; kif.block_in = 0;
        chk("tmo0_done", {run_count[3:0], busy}, {4'd1, 1'b0});
        rst_dut();
        timeout = 2; enable = 1;
        tick(); kif.ap_ready = 1; tick(); kif.ap_ready = 0; enable = 0;
        kif.block_in = 1; repeat (2) tick();
        chk("ar_flush", {kif.kernel_rst, deadlock, busy}, 3'b111);
        repeat (2) tick();
        #2 reset = 1;
        #1;
        chk("ar_async", {kif.kernel_rst, deadlock, busy}, 3'b000);
        chk("ar_aborts", abort_count, 0);
        reset = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
